// File: rtl/mem_access_queue_pkg.sv
// Shared types for the data-memory access path.
// Bus request/response bundles, access sizes and address-error codes.
package mem_access_queue_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2
   } msize_t;

   typedef enum logic [4:0] {
      EX_ADEL = 5'h04,
      EX_ADES = 5'h05
   } exc_code_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   function automatic logic is_misaligned(
      input msize_t     sz,
      input logic [1:0] lo
   );
      return ((sz == MSIZE2) && lo[0]) ||
             ((sz == MSIZE4) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load lane extraction: shift the addressed bytes down,
// truncate to the access size and sign- or zero-extend.
module mem_lane_align
   import mem_access_queue_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_addr_lo,
   input  msize_t      i_msize,
   input  logic        i_sign,
   output logic [31:0] o_data
);

   logic [31:0] w_sh;

   assign w_sh = i_data >> {i_addr_lo, 3'b000};

   always_comb begin
      o_data = w_sh;
      unique case (i_msize)
         MSIZE1:  o_data = {{24{i_sign & w_sh[7]}}, w_sh[7:0]};
         MSIZE2:  o_data = {{16{i_sign & w_sh[15]}}, w_sh[15:0]};
         default: o_data = w_sh;
      endcase
   end

endmodule

// File: rtl/mem_access_queue.sv
// In-order memory access queue between the pipeline and the data bus.
// Tracks outstanding requests, reports address errors and retires in order.
module mem_access_queue
   import mem_access_queue_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int TAG_W       = 5,
   parameter bit CHECK_ALIGN = 1'b1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_write,
   input  msize_t           in_msize,
   input  logic             in_sign,
   input  logic [31:0]      in_addr,
   input  logic [31:0]      in_wdata,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output dbus_req_t        dreq,
   input  dbus_resp_t       dresp,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_write,
   output logic [31:0]      out_rdata,
   output logic             out_exc_valid,
   output exc_code_t        out_exc_code,
   output logic [31:0]      out_badvaddr
);

   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = PW + 1;

   logic [TAG_W-1:0]       r_tag   [OUTSTANDING];
   msize_t                 r_msize [OUTSTANDING];
   logic [31:0]            r_addr  [OUTSTANDING];
   logic [OUTSTANDING-1:0] r_sign;
   logic [OUTSTANDING-1:0] r_write;
   logic [OUTSTANDING-1:0] r_exc;
   logic [OUTSTANDING-1:0] r_killed;
   logic [OUTSTANDING-1:0] r_vld;
   logic [PW-1:0]          r_head;
   logic [PW-1:0]          r_tail;
   logic [CW-1:0]          r_count;

   logic             w_mis;
   logic             w_notfull;
   logic             w_empty;
   logic             w_has_exc;
   logic             w_bus_req;
   logic             w_bus_acc;
   logic             w_exc_acc;
   logic             w_head_exc;
   logic             w_ret_bus;
   logic             w_bypass;
   logic             w_deq;
   logic             w_enq;
   logic             w_r_kill;
   logic             w_r_write;
   logic             w_r_sign;
   msize_t           w_r_msize;
   logic [31:0]      w_r_addr;
   logic [TAG_W-1:0] w_r_tag;
   logic [31:0]      w_ldata;

   assign w_mis     = CHECK_ALIGN && is_misaligned(in_msize, in_addr[1:0]);
   assign w_notfull = r_count < CW'(OUTSTANDING);
   assign w_empty   = (r_count == '0);
   assign w_has_exc = |(r_vld & r_exc);

   // Bus issue stalls while an error entry is queued, so a data_ok
   // can never arrive while an error entry occupies the head.
   assign w_bus_req = !reset && in_valid && !w_mis && !flush &&
                      w_notfull && !w_has_exc;
   assign w_bus_acc = w_bus_req && dresp.addr_ok;
   assign w_exc_acc = !reset && in_valid && w_mis && !flush && w_notfull;
   assign in_ready  = w_bus_acc || w_exc_acc;

   assign w_head_exc = !reset && !w_empty && r_exc[r_head];
   assign w_ret_bus  = !reset && !w_empty && !r_exc[r_head] &&
                       dresp.data_ok;
   assign w_bypass   = w_empty && w_bus_acc && dresp.data_ok;
   assign w_deq      = w_head_exc || w_ret_bus;
   assign w_enq      = in_ready && !w_bypass;

   assign w_r_tag   = w_bypass ? in_tag   : r_tag[r_head];
   assign w_r_msize = w_bypass ? in_msize : r_msize[r_head];
   assign w_r_addr  = w_bypass ? in_addr  : r_addr[r_head];
   assign w_r_sign  = w_bypass ? in_sign  : r_sign[r_head];
   assign w_r_write = w_bypass ? in_write : r_write[r_head];
   assign w_r_kill  = !w_bypass && (r_killed[r_head] || flush);

   mem_lane_align u_align (
      .i_data    (dresp.data),
      .i_addr_lo (w_r_addr[1:0]),
      .i_msize   (w_r_msize),
      .i_sign    (w_r_sign),
      .o_data    (w_ldata)
   );

   always_comb begin
      out_valid     = (w_deq || w_bypass) && !w_r_kill;
      out_exc_valid = w_head_exc && !w_r_kill;
      out_tag       = out_valid ? w_r_tag : '0;
      out_write     = out_valid && w_r_write;
      out_rdata     = '0;
      if (out_valid && !w_r_write && !w_head_exc) out_rdata = w_ldata;
      out_exc_code  = exc_code_t'(5'd0);
      if (out_exc_valid) out_exc_code = w_r_write ? EX_ADES : EX_ADEL;
      out_badvaddr  = out_exc_valid ? w_r_addr : '0;
   end

   always_comb begin
      dreq       = '0;
      dreq.valid = w_bus_req;
      if (!reset) begin
         dreq.addr = in_addr;
         dreq.size = in_msize;
         if (in_write) begin
            unique case (in_msize)
               MSIZE1: begin
                  dreq.strobe = 4'b0001 << in_addr[1:0];
                  dreq.data   = {4{in_wdata[7:0]}};
               end
               MSIZE2: begin
                  dreq.strobe = 4'b0011 << in_addr[1:0];
                  dreq.data   = {2{in_wdata[15:0]}};
               end
               default: begin
                  dreq.strobe = 4'b1111;
                  dreq.data   = in_wdata;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_sign   <= '0;
         r_write  <= '0;
         r_exc    <= '0;
         r_killed <= '0;
         r_vld    <= '0;
         for (int i = 0; i < OUTSTANDING; i++) begin
            r_tag[i]   <= '0;
            r_msize[i] <= MSIZE1;
            r_addr[i]  <= '0;
         end
      end else begin
         if (flush) r_killed <= r_killed | r_vld;
         if (w_enq) begin
            r_tag[r_tail]    <= in_tag;
            r_msize[r_tail]  <= in_msize;
            r_addr[r_tail]   <= in_addr;
            r_sign[r_tail]   <= in_sign;
            r_write[r_tail]  <= in_write;
            r_exc[r_tail]    <= w_mis;
            r_killed[r_tail] <= 1'b0;
            r_vld[r_tail]    <= 1'b1;
            r_tail           <= r_tail + PW'(1);
         end
         if (w_deq) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + PW'(1);
         end
         if (w_enq && !w_deq) r_count <= r_count + CW'(1);
         else if (!w_enq && w_deq) r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: doc/mem_access_queue.md
MEM_ACCESS_QUEUE -- requirements
Module: mem_access_queue

Interface
REQ-001 Parameter OUTSTANDING, default 2: maximum requests in flight (accepted, awaiting data_ok); power of 2, at least 2.
REQ-002 Parameter TAG_W, default 5: width of the caller tag, normally the destination register.
REQ-003 Parameter CHECK_ALIGN, default 1: 1 enables address-error detection; 0 forwards every request to the bus.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  access request valid; held stable until in_ready.
REQ-007 in_ready  out  1  request consumed this cycle.
REQ-008 in_write  in  1  1 store, 0 load.
REQ-009 in_msize  in  msize_t  MSIZE1, MSIZE2 or MSIZE4.
REQ-010 in_sign  in  1  load sign-extends.
REQ-011 in_addr  in  32  byte address.
REQ-012 in_wdata  in  32  store data, right-aligned.
REQ-013 in_tag  in  TAG_W  returned with the result.
REQ-014 flush  in  1  kill all queued and presented requests.
REQ-015 dreq  out  dbus_req_t  data bus request.
REQ-016 dresp  in  dbus_resp_t  data bus response (addr_ok, data_ok, data).
REQ-017 out_valid  out  1  one-cycle retire pulse.
REQ-018 out_tag, out_write  out  TAG_W, 1  retired entry's tag and store flag.
REQ-019 out_rdata  out  32  extended load data; 0 for stores.
REQ-020 out_exc_valid, out_exc_code, out_badvaddr  out  1, exc_code_t, 32  address-error report.

Function
REQ-021 Misaligned when CHECK_ALIGN=1 and either MSIZE2 with addr[0]=1, or MSIZE4 with addr[1:0]!=0.
REQ-022 Internal queue SHALL hold OUTSTANDING entries: tag, msize, addr, sign, write, is_exc, killed. Head and tail pointers wrap modulo OUTSTANDING; occupancy counter runs 0..OUTSTANDING.
REQ-023 dreq.valid = in_valid && !misaligned && !flush && count<OUTSTANDING; this SHALL have no combinational path from dresp.data_ok.
REQ-024 dreq.addr = in_addr and dreq.size = in_msize.
REQ-025 Loads drive strobe 0. Stores drive strobe MSIZE1 0001<<a, MSIZE2 0011<<a, MSIZE4 1111, where a = addr[1:0].
REQ-026 Store data SHALL be replicated across lanes (byte x4, half x2).
REQ-027 Bus request accepted when dreq.valid && dresp.addr_ok: in_ready=1 and the entry is enqueued.
REQ-028 Misaligned request with in_valid, !flush and count<OUTSTANDING: in_ready=1; enqueue an is_exc entry; no bus request.
REQ-029 dresp.data_ok always belongs to the oldest bus entry. If the queue is empty and a request is accepted that same cycle, data_ok belongs to that request, which retires in the same cycle without being enqueued.
REQ-030 Head is_exc entry retires the cycle after it is enqueued or reaches the head: out_exc_valid=1, code EX_ADEL for loads or EX_ADES for stores, out_badvaddr=addr.
REQ-031 Head bus entry retires on data_ok.
REQ-032 Load data = dresp.data >> 8*a, truncated to msize, then sign- or zero-extended per sign.
REQ-033 At most one retirement per cycle. Enqueue and dequeue in the same cycle leave count unchanged.
REQ-034 flush sets killed on every queued entry and blocks acceptance that cycle.
REQ-035 Killed bus entries still consume their data_ok; killed entries retire with out_valid=0.
REQ-036 Queue full: in_ready=0 and dreq.valid=0 until count drops on a clock edge.

Reset
REQ-037 While reset: queue empty, pointers 0, count 0, all outputs 0.
REQ-038 Reset mid-operation discards in-flight entries; the bus is reset alongside.

Structure
REQ-039 msize_t, exc_code_t (EX_ADEL, EX_ADES), dbus_req_t and dbus_resp_t come from the shared package.
REQ-040 Lane extraction/extension is sub-module mem_lane_align (combinational, reused by other stages).

Verification
REQ-041 LW 0x1000 with addr_ok and data_ok same cycle, data 0xDEADBEEF -> out_valid same cycle, rdata 0xDEADBEEF, queue stays empty.
REQ-042 LB signed at 0x1003, response data 0x80FFFFFF -> rdata 0xFFFFFF80; LBU gives 0x00000080.
REQ-043 SH 0x2002, wdata 0x1234 -> strobe 1100, data 0x12341234; out_valid on data_ok with out_write=1.
REQ-044 OUTSTANDING=2: three loads, data_ok withheld -> two accepted, third waits with dreq.valid=0; responses retire in order, then the third is issued.
REQ-045 LW 0x1001 behind one pending load -> no bus request; ADEL retires after the load, badvaddr 0x1001.
REQ-046 flush with two entries pending -> both data_ok consumed, no out_valid; next request proceeds normally.
